memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Sole owner of the single-ported unified RAM. Accepts instruction-fetch and data requests from the
//  pipeline and serialises them onto the RAM bus. Returns one-cycle ihit/dhit pulses plus load data;
//  the hazard unit consumes these pulses to advance the pipeline latches and the PC.
//  Data requests win by default; under contention the block alternates so fetch never starves.
// PARAMETERS
//  TIMEOUT   64  max cycles an access may wait for ram_ready before it is aborted (>=2)
// PORTS
//  CLK        in   1   clock; all state updates on rising edge
//  RST        in   1   reset, synchronous, active-high
//  iREN       in   1   instruction fetch request (level, held until ihit)
//  iaddr      in   32  fetch address (word_t)
//  dREN       in   1   data read request (level, held until dhit)
//  dWEN       in   1   data write request (level, held until dhit)
//  daddr      in   32  data address
//  dstore     in   32  write data
//  halt       in   1   pipeline halted: no new fetch accepted
//  ihit       out  1   one-cycle pulse: fetch complete, iload valid this cycle
//  iload      out  32  fetched instruction (registered)
//  dhit       out  1   one-cycle pulse: data access complete, dload valid this cycle
//  dload      out  32  read data (registered; 0 for writes)
//  ram_ren    out  1   RAM read strobe
//  ram_wen    out  1   RAM write strobe
//  ram_addr   out  32  RAM address
//  ram_store  out  32  RAM write data
//  ram_ready  in   1   RAM completes the current access this cycle
//  ram_load   in   32  RAM read data, valid with ram_ready
//  mem_err    out  1   sticky: some access timed out
// BEHAVIOUR
//  - Reset (sync, RST=1 at edge): state IDLE; all outputs 0; counter 0; last_d=0; mem_err=0.
//    Reset mid-access drops ram_ren/ram_wen on that same edge; no hit is issued for the aborted access.
//  - State machine states: IDLE, DACC, IACC, RESP.
//  - IDLE: dreq = dREN|dWEN; ireq = iREN & !halt.
//    Grant rule: data wins, except when dreq&ireq&last_d -> grant instruction.
//    - Data grant: latch daddr, dstore, wr=dWEN; last_d<=1; -> DACC.
//    - Instruction grant: latch iaddr; last_d<=0; -> IACC.
//    - If neither request is present, stay IDLE.
//  - dREN&dWEN both high: treated as a write.
//  - DACC/IACC: drive ram_addr/ram_store/strobes from latched values (registered; stable for whole access).
//    Counter increments each cycle.
//    - On ram_ready: capture ram_load into dload/iload (dload=0 on write); -> RESP.
//    - If the counter reaches TIMEOUT-1 with no ram_ready: drop strobes, set mem_err, load=0; -> RESP.
//  - RESP: strobes low; the matching hit output is 1 for exactly this cycle; -> IDLE.
//    The requester updates its request at the following edge, so IDLE never re-serves a stale request.
//  - Minimum latency: request seen in IDLE at edge N, ram_ready at N+1, hit high during cycle N+2.
//  - ihit and dhit are never high together. Strobes are never high in IDLE or RESP.
//  - Requests dropped mid-access: the access completes anyway; its hit pulse is still issued.
//  - halt only gates new fetch grants; data requests are still served.
//  - Counter width: $clog2(TIMEOUT); it clears on entry to DACC/IACC.
// STRUCTURE
//  - cpu_types_pkg gains: typedef enum logic[1:0] {IDLE,DACC,IACC,RESP} arb_state_t.
//    word_t (32b) is reused from the package.
//  - One sub-module is natural: mem_timeout_ctr (clear/enable/expire, parameter TIMEOUT).
//    Everything else sits in a single always_ff plus one always_comb next-state block.
// TESTING
//  - Reset then idle: RST 1 for 2 cycles, no requests -> all outputs 0, ram strobes 0.
//  - Fetch: iREN=1, iaddr=0x40; RAM ready 3 cycles after strobe with ram_load=0x8C220004
//    -> ram_addr=0x40, ram_ren=1 for 3 cycles, then ihit for 1 cycle with iload=0x8C220004.
//  - Write: dWEN=1, daddr=0x100, dstore=0xCAFEF00D -> ram_wen=1, ram_store=0xCAFEF00D,
//    then dhit for 1 cycle with dload=0.
//  - Contention: iREN and dREN held continuously -> grants alternate D,I,D,I
//    (first grant is D after reset); ihit/dhit never coincide.
//  - Timeout: TIMEOUT=8, ram_ready never asserted -> strobes drop after 8 cycles, hit pulses,
//    load=0, mem_err=1 until RST.
//  - Reset mid-access, and halt: RST mid-DACC -> strobes 0 at next edge and no dhit;
//    halt=1 with iREN=1 -> no fetch granted, while dREN is still served.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the memory arbiter state encoding.
// Pure declarations; no logic, no latency.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        DACC,
        IACC,
        RESP
    } arb_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Access watchdog: counts cycles while enabled and flags expiry on the TIMEOUT-th cycle.
// Combinational expire from a registered count; clear has priority over enable.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (cnt == LAST);

endmodule

// File: rtl/memory_arbiter.sv
// Serialises fetch and data requests onto the single-ported RAM; data wins unless it won last time.
// Min latency: request at edge N, ram_ready at N+1, hit during cycle N+2; requesters hold until hit.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  iREN,
    input  word_t iaddr,
    input  logic  dREN,
    input  logic  dWEN,
    input  word_t daddr,
    input  word_t dstore,
    input  logic  halt,
    output logic  ihit,
    output word_t iload,
    output logic  dhit,
    output word_t dload,
    output logic  ram_ren,
    output logic  ram_wen,
    output word_t ram_addr,
    output word_t ram_store,
    input  logic  ram_ready,
    input  word_t ram_load,
    output logic  mem_err
);

    arb_state_t state, state_nxt;
    logic       last_d;
    logic       cur_d;
    logic       dreq, ireq;
    logic       grant_d, grant_i;
    logic       in_acc;
    logic       expire;
    logic       acc_done;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .clk    (CLK),
        .rst    (RST),
        .clr    (state == IDLE),
        .en     (in_acc),
        .expire (expire)
    );

    assign dreq     = dREN | dWEN;
    assign ireq     = iREN & ~halt;
    // Fetch only takes the slot from data when data was served last.
    assign grant_i  = ireq & ~(dreq & ~last_d);
    assign grant_d  = dreq & ~grant_i;
    assign in_acc   = (state == DACC) || (state == IACC);
    assign acc_done = in_acc & (ram_ready | expire);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            cur_d     <= 1'b0;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_store <= '0;
            iload     <= '0;
            dload     <= '0;
            mem_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (grant_d) begin
                    cur_d     <= 1'b1;
                    last_d    <= 1'b1;
                    ram_addr  <= daddr;
                    ram_store <= dstore;
                    ram_wen   <= dWEN;
                    ram_ren   <= ~dWEN;
                end else if (grant_i) begin
                    cur_d     <= 1'b0;
                    last_d    <= 1'b0;
                    ram_addr  <= iaddr;
                    ram_store <= '0;
                    ram_ren   <= 1'b1;
                    ram_wen   <= 1'b0;
                end
            end else if (acc_done) begin
                ram_ren <= 1'b0;
                ram_wen <= 1'b0;
                if (state == DACC) begin
                    dload <= (ram_ready && !ram_wen) ? ram_load : '0;
                end else begin
                    iload <= ram_ready ? ram_load : '0;
                end
                if (!ram_ready) begin
                    mem_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d)      state_nxt = DACC;
                else if (grant_i) state_nxt = IACC;
            end
            DACC, IACC: begin
                if (acc_done) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ihit = 1'b0;
        dhit = 1'b0;
        if (state == RESP) begin
            ihit = ~cur_d;
            dhit = cur_d;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter (TIMEOUT=8): inputs driven 1 time unit after the rising edge,
// outputs checked at the same point, so each tick() lands in the next cycle.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  RST, iREN, dREN, dWEN, halt, ram_ready;
    word_t iaddr, daddr, dstore, ram_load;
    logic  ihit, dhit, ram_ren, ram_wen, mem_err;
    word_t iload, dload, ram_addr, ram_store;

    int checks = 0;
    int passed = 0;

    memory_arbiter #(.TIMEOUT(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .halt      (halt),
        .ihit      (ihit),
        .iload     (iload),
        .dhit      (dhit),
        .dload     (dload),
        .ram_ren   (ram_ren),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_store (ram_store),
        .ram_ready (ram_ready),
        .ram_load  (ram_load),
        .mem_err   (mem_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; halt = 0; ram_ready = 0;
        iaddr = '0; daddr = '0; dstore = '0; ram_load = '0;
        tick(); tick();
        RST = 1'b0;
        checks++; if ({ihit, dhit, ram_ren, ram_wen, mem_err} !== 5'b0)
            $display("FAIL reset_ctrl got %b want 00000", {ihit, dhit, ram_ren, ram_wen, mem_err}); else passed++;
        checks++; if ({iload, dload, ram_addr, ram_store} !== 128'h0)
            $display("FAIL reset_data got %h/%h/%h/%h want 0", iload, dload, ram_addr, ram_store); else passed++;
        tick(); tick();
        checks++; if ({ihit, dhit, ram_ren, ram_wen} !== 4'b0)
            $display("FAIL idle_quiet got %b want 0000", {ihit, dhit, ram_ren, ram_wen}); else passed++;
    endtask

    task automatic test_fetch();
        iREN = 1'b1; iaddr = 32'h40;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (ram_ren !== 1'b1 || ram_wen !== 1'b0 || ram_addr !== 32'h40 || ihit !== 1'b0)
                $display("FAIL fetch_strobe%0d got ren=%b wen=%b addr=%h ihit=%b want 1 0 40 0",
                         i, ram_ren, ram_wen, ram_addr, ihit); else passed++;
            if (i == 2) begin
                ram_ready = 1'b1; ram_load = 32'h8C220004;
            end
            if (i < 2) tick();
        end
        tick();
        ram_ready = 1'b0; iREN = 1'b0;
        checks++; if (ihit !== 1'b1 || dhit !== 1'b0 || ram_ren !== 1'b0)
            $display("FAIL fetch_hit got ihit=%b dhit=%b ren=%b want 1 0 0", ihit, dhit, ram_ren); else passed++;
        checks++; if (iload !== 32'h8C220004)
            $display("FAIL fetch_iload got %h want 8c220004", iload); else passed++;
        tick();
        checks++; if (ihit !== 1'b0 || ram_ren !== 1'b0)
            $display("FAIL fetch_after got ihit=%b ren=%b want 0 0", ihit, ram_ren); else passed++;
    endtask

    task automatic test_read_write();
        dREN = 1'b1; daddr = 32'h200;
        tick();
        ram_ready = 1'b1; ram_load = 32'h12345678;
        checks++; if (ram_ren !== 1'b1 || ram_wen !== 1'b0 || ram_addr !== 32'h200)
            $display("FAIL read_strobe got ren=%b wen=%b addr=%h want 1 0 200", ram_ren, ram_wen, ram_addr); else passed++;
        tick();
        dREN = 1'b0; ram_ready = 1'b0;
        checks++; if (dhit !== 1'b1 || ihit !== 1'b0 || dload !== 32'h12345678)
            $display("FAIL read_hit got dhit=%b ihit=%b dload=%h want 1 0 12345678", dhit, ihit, dload); else passed++;
        tick();
        // Write with read also asserted: must be treated as a write.
        dWEN = 1'b1; dREN = 1'b1; daddr = 32'h100; dstore = 32'hCAFEF00D;
        tick();
        ram_ready = 1'b1; ram_load = 32'hFFFFFFFF;
        checks++; if (ram_wen !== 1'b1 || ram_ren !== 1'b0 || ram_addr !== 32'h100 || ram_store !== 32'hCAFEF00D)
            $display("FAIL write_strobe got wen=%b ren=%b addr=%h store=%h want 1 0 100 cafef00d",
                     ram_wen, ram_ren, ram_addr, ram_store); else passed++;
        tick();
        dWEN = 1'b0; dREN = 1'b0; ram_ready = 1'b0;
        checks++; if (dhit !== 1'b1 || dload !== 32'h0 || ram_wen !== 1'b0)
            $display("FAIL write_hit got dhit=%b dload=%h wen=%b want 1 0 0", dhit, dload, ram_wen); else passed++;
        tick();
        checks++; if (dhit !== 1'b0)
            $display("FAIL write_after got dhit=%b want 0", dhit); else passed++;
    endtask

    task automatic test_contention();
        int   nh;
        logic exp_d;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h300;
        ram_ready = 1'b1; ram_load = 32'hDEADBEEF;
        nh = 0; exp_d = 1'b1;
        for (int c = 0; c < 30 && nh < 4; c++) begin
            tick();
            checks++; if ((ihit & dhit) !== 1'b0)
                $display("FAIL cont_coincide cycle %0d got ihit=%b dhit=%b want not both", c, ihit, dhit); else passed++;
            if (ihit || dhit) begin
                checks++; if (dhit !== exp_d)
                    $display("FAIL cont_order hit %0d got dhit=%b want %b", nh, dhit, exp_d); else passed++;
                exp_d = ~exp_d;
                nh++;
            end
        end
        iREN = 1'b0; dREN = 1'b0;
        checks++; if (nh !== 4)
            $display("FAIL cont_count got %0d hits want 4", nh); else passed++;
        ram_ready = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_timeout();
        checks++; if (mem_err !== 1'b0 || dload !== 32'hDEADBEEF)
            $display("FAIL to_pre got err=%b dload=%h want 0 deadbeef", mem_err, dload); else passed++;
        dREN = 1'b1; daddr = 32'h80; ram_load = 32'h11111111;
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++; if (ram_ren !== 1'b1 || dhit !== 1'b0)
                $display("FAIL to_strobe%0d got ren=%b dhit=%b want 1 0", i, ram_ren, dhit); else passed++;
            tick();
        end
        dREN = 1'b0;
        checks++; if (ram_ren !== 1'b0 || dhit !== 1'b1 || dload !== 32'h0 || mem_err !== 1'b1)
            $display("FAIL to_resp got ren=%b dhit=%b dload=%h err=%b want 0 1 0 1", ram_ren, dhit, dload, mem_err); else passed++;
        tick(); tick(); tick();
        checks++; if (mem_err !== 1'b1)
            $display("FAIL to_sticky got err=%b want 1", mem_err); else passed++;
    endtask

    task automatic test_reset_mid_and_halt();
        int hits;
        dREN = 1'b1; daddr = 32'h88;
        tick();
        checks++; if (ram_ren !== 1'b1)
            $display("FAIL rmid_strobe got ren=%b want 1", ram_ren); else passed++;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0; dREN = 1'b0;
        checks++; if (ram_ren !== 1'b0 || ram_wen !== 1'b0 || dhit !== 1'b0 || mem_err !== 1'b0)
            $display("FAIL rmid_drop got ren=%b wen=%b dhit=%b err=%b want 0 0 0 0", ram_ren, ram_wen, dhit, mem_err); else passed++;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            hits += int'(dhit) + int'(ihit);
        end
        checks++; if (hits !== 0)
            $display("FAIL rmid_nohit got %0d hits want 0", hits); else passed++;

        halt = 1'b1; iREN = 1'b1; iaddr = 32'h48;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ram_ren !== 1'b0 || ihit !== 1'b0)
                $display("FAIL halt_nofetch%0d got ren=%b ihit=%b want 0 0", i, ram_ren, ihit); else passed++;
        end
        dREN = 1'b1; daddr = 32'h204;
        tick();
        ram_ready = 1'b1; ram_load = 32'h55;
        checks++; if (ram_ren !== 1'b1 || ram_addr !== 32'h204)
            $display("FAIL halt_data got ren=%b addr=%h want 1 204", ram_ren, ram_addr); else passed++;
        tick();
        dREN = 1'b0; ram_ready = 1'b0;
        checks++; if (dhit !== 1'b1 || ihit !== 1'b0 || dload !== 32'h55)
            $display("FAIL halt_dhit got dhit=%b ihit=%b dload=%h want 1 0 55", dhit, ihit, dload); else passed++;
        tick(); tick();
        checks++; if (ram_ren !== 1'b0)
            $display("FAIL halt_still got ren=%b want 0", ram_ren); else passed++;
        halt = 1'b0;
        tick();
        checks++; if (ram_ren !== 1'b1 || ram_addr !== 32'h48)
            $display("FAIL unhalt_fetch got ren=%b addr=%h want 1 48", ram_ren, ram_addr); else passed++;
        iREN = 1'b0;
        ram_ready = 1'b1;
        tick(); tick();
        ram_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_read_write();
        test_contention();
        test_timeout();
        test_reset_mid_and_halt();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
